numbers_multi: RTL and testbench
================================

Name: numbers_multi

Overview:
- Parametrised successor of the single bouncing-number block: N independent numbers bounce around the screen, each rendered as a 7-segment decimal digit.
- Combines dynamics (position, direction, shared velocity, digit advance on each bounce) and graphics (per-pixel colour) in one block.
- Drives the VGA colour path and the sound unit.
- Moves once per frame on a frame strobe from the sync generator.

Parameters:
- N_NUM, 2: number of bouncing digits (1..7).
- SCR_W, 640: visible width in pixels.
- SCR_H, 480: visible height in pixels.
- DIG_W, 16: digit box width.
- DIG_H, 28: digit box height.
- SEG_T, 4: segment thickness.
- VEL_MAX, 7: maximum velocity, in pixels per frame.
- VEL_RST, 1: velocity after reset.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; asynchronous, active-low.
- frame  in  1  one-cycle strobe, once per frame, issued during blanking.
- x_px  in  10  current pixel X.
- y_px  in  10  current pixel Y.
- color_px  out  3  pixel colour; 1-cycle latency.
- inc_vel  in  1  level, synchronous and debounced; a rising edge increments velocity.
- dec_vel  in  1  level, synchronous and debounced; a rising edge decrements velocity.
- mute  out  1  high while velocity = 0.
- code_sound  out  2  sound code: 00 ping (X wall), 01 pong (Y wall), 10 go, 11 stop.
- snd_valid  out  1  one-cycle pulse; code_sound is valid with it.

Behaviour:
- Reset (clr=0), asynchronous, values for channel i:
  - x[i]=32+64*i, y[i]=32+48*i.
  - dx[i]=+; dy[i]=+ for even i, − for odd i.
  - digit[i]=i mod 10.
  - vel=VEL_RST.
  - color_px=0, snd_valid=0, code_sound=00, mute=(VEL_RST==0).
  - Edge-detect registers cleared.
  - Reset mid-frame or mid-pulse: all of the above are restored immediately; no sound event is issued.
- Velocity (shared by all channels, 3 bits):
  - Rising edge of inc_vel: vel=min(vel+1, VEL_MAX).
  - Rising edge of dec_vel: vel=max(vel−1, 0).
  - Both edges in the same cycle: no change.
  - Saturated request (vel already at the limit): no change and no event.
  - Transition 0→1: go event. Transition 1→0: stop event.
- Motion, on a cycle with frame=1, per channel, using the velocity value before any same-cycle update. X axis (Y is identical with SCR_H/DIG_H):
  - If dx=+ and x+vel ≥ SCR_W−DIG_W: x=SCR_W−DIG_W, dx flips, X-bounce.
  - If dx=− and x ≤ vel: x=0, dx flips, X-bounce.
  - Otherwise x±=vel.
  - Arithmetic is in 11 bits; no wrap-around is permitted.
  - vel=0: positions are frozen and no bounces occur.
- Digit:
  - On any bounce (X, Y or corner) digit[i]=(digit[i]+1) mod 10.
  - Increments exactly once per frame per channel, even for a corner bounce.
- Sound, registered:
  - snd_valid rises the cycle after the triggering edge.
  - At most one event per cycle, chosen by priority: stop/go > pong > ping.
  - Among bounces, the lowest channel index wins.
  - Losing events are dropped.
  - mute is registered and equals (vel==0).
- Graphics, 1-cycle registered latency:
  - Channel i is inside its box when x[i] ≤ x_px < x[i]+DIG_W and y[i] ≤ y_px < y[i]+DIG_H.
  - Local coordinates u, v are relative to the box; m=(DIG_H−SEG_T)/2.
  - Segments:
    - a: v<SEG_T.
    - g: m≤v<m+SEG_T.
    - d: v≥DIG_H−SEG_T.
    - f: u<SEG_T, v<m+SEG_T.
    - b: u≥DIG_W−SEG_T, v<m+SEG_T.
    - e: u<SEG_T, v≥m.
    - c: u≥DIG_W−SEG_T, v≥m.
  - Digits 0–9 use the standard 7-segment patterns.
  - A lit pixel takes colour i+1. Overlapping channels: lowest index wins. Outside all lit segments: 000.
  - Positions change only on frame; tear-free display is the sync generator's responsibility (frame is issued in blanking).

Test Plan:
- Reset with N_NUM=2 → x0=32, y0=32, x1=96, y1=80, digits 0/1, vel=1, mute=0, color_px=0, snd_valid=0.
- Digit 0 of channel 0 at (32,32); drive pixels (32,32), (38,44), (38,38) → color_px 001, 000, 000 one cycle later (segment a lit, g dark, box interior dark).
- Force vel=7 and x0=620 with dx=+, then pulse frame → x0=624, dx=−, digit0 advances 0→1, snd_valid pulse with code 00 on the next cycle.
- Channel 0 placed to hit a corner (both walls in one frame) → both directions flip, digit advances by exactly 1, code_sound=01.
- From vel=1: dec_vel edge → vel=0, mute=1, code 11. A frame while vel=0 → no movement. inc_vel edge → code 10, mute=0.
- inc_vel edge at vel=7 → no change and no snd_valid. inc_vel and dec_vel edges in the same cycle → vel unchanged. inc_vel edge coinciding with frame → motion uses the old vel; go/stop takes priority over a same-cycle bounce sound.

Source files
------------

// File: rtl/numbers_multi_if.sv
// Pixel, frame, velocity-button and sound signals of the bouncing-digits block.
// The master side (sync generator / buttons) drives; the block is the slave.
interface numbers_multi_if;
  logic       frame;
  logic [9:0] x_px;
  logic [9:0] y_px;
  logic [2:0] color_px;
  logic       inc_vel;
  logic       dec_vel;
  logic       mute;
  logic [1:0] code_sound;
  logic       snd_valid;

  modport master (
    output frame, x_px, y_px, inc_vel, dec_vel,
    input  color_px, mute, code_sound, snd_valid
  );

  modport slave (
    input  frame, x_px, y_px, inc_vel, dec_vel,
    output color_px, mute, code_sound, snd_valid
  );
endinterface

// File: rtl/numbers_multi.sv
// N bouncing 7-segment digits sharing one velocity; each bounce advances its digit
// and may raise a sound event. Colour output is registered, one cycle behind the pixel.
module numbers_multi #(
  parameter int unsigned N_NUM   = 2,
  parameter int unsigned SCR_W   = 640,
  parameter int unsigned SCR_H   = 480,
  parameter int unsigned DIG_W   = 16,
  parameter int unsigned DIG_H   = 28,
  parameter int unsigned SEG_T   = 4,
  parameter int unsigned VEL_MAX = 7,
  parameter int unsigned VEL_RST = 1
) (
  input logic           clk,
  input logic           clr,
  numbers_multi_if.slave bus
);

  localparam logic [10:0] XLim   = 11'(SCR_W - DIG_W);
  localparam logic [10:0] YLim   = 11'(SCR_H - DIG_H);
  localparam logic [10:0] DigW   = 11'(DIG_W);
  localparam logic [10:0] DigH   = 11'(DIG_H);
  localparam logic [10:0] SegT   = 11'(SEG_T);
  localparam logic [10:0] SegM   = 11'((DIG_H - SEG_T) / 2);
  localparam logic [2:0]  VelMax = 3'(VEL_MAX);
  localparam logic [2:0]  VelRst = 3'(VEL_RST);

  typedef enum logic [1:0] {
    SndPing = 2'b00,
    SndPong = 2'b01,
    SndGo   = 2'b10,
    SndStop = 2'b11
  } snd_e;

  logic [N_NUM-1:0][10:0] x_q, x_d, y_q, y_d;
  logic [N_NUM-1:0][3:0]  dig_q, dig_d;
  logic [N_NUM-1:0]       dx_q, dx_d, dy_q, dy_d;
  logic [N_NUM-1:0]       bounce_x, bounce_y;
  logic [2:0]             vel_q, vel_d;
  logic                   inc_q, dec_q, inc_edge, dec_edge;
  logic                   go, stop;
  logic                   snd_valid_q, snd_valid_d;
  snd_e                   code_q, code_d;
  logic                   mute_q;
  logic [2:0]             color_q, color_d;

  // Segment enables for a decimal digit, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'b1111110;
      4'd1:    seg_pattern = 7'b0110000;
      4'd2:    seg_pattern = 7'b1101101;
      4'd3:    seg_pattern = 7'b1111001;
      4'd4:    seg_pattern = 7'b0110011;
      4'd5:    seg_pattern = 7'b1011011;
      4'd6:    seg_pattern = 7'b1011111;
      4'd7:    seg_pattern = 7'b1110000;
      4'd8:    seg_pattern = 7'b1111111;
      4'd9:    seg_pattern = 7'b1111011;
      default: seg_pattern = 7'b0000000;
    endcase
  endfunction

  // Opposing edges in one cycle cancel; saturated requests are ignored silently.
  always_comb begin
    inc_edge = bus.inc_vel & ~inc_q;
    dec_edge = bus.dec_vel & ~dec_q;
    vel_d    = vel_q;
    go       = 1'b0;
    stop     = 1'b0;
    if (inc_edge && !dec_edge && vel_q != VelMax) begin
      vel_d = vel_q + 3'd1;
      go    = (vel_q == 3'd0);
    end else if (dec_edge && !inc_edge && vel_q != 3'd0) begin
      vel_d = vel_q - 3'd1;
      stop  = (vel_q == 3'd1);
    end
  end

  // Motion always uses the velocity held before this cycle's button update.
  always_comb begin
    logic [10:0] vel_w;
    vel_w    = {8'd0, vel_q};
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    dig_d    = dig_q;
    bounce_x = '0;
    bounce_y = '0;
    if (bus.frame && vel_q != 3'd0) begin
      for (int unsigned i = 0; i < N_NUM; i++) begin
        if (dx_q[i]) begin
          if (x_q[i] + vel_w >= XLim) begin
            x_d[i] = XLim;  dx_d[i] = 1'b0;  bounce_x[i] = 1'b1;
          end else begin
            x_d[i] = x_q[i] + vel_w;
          end
        end else if (x_q[i] <= vel_w) begin
          x_d[i] = 11'd0;  dx_d[i] = 1'b1;  bounce_x[i] = 1'b1;
        end else begin
          x_d[i] = x_q[i] - vel_w;
        end
        if (dy_q[i]) begin
          if (y_q[i] + vel_w >= YLim) begin
            y_d[i] = YLim;  dy_d[i] = 1'b0;  bounce_y[i] = 1'b1;
          end else begin
            y_d[i] = y_q[i] + vel_w;
          end
        end else if (y_q[i] <= vel_w) begin
          y_d[i] = 11'd0;  dy_d[i] = 1'b1;  bounce_y[i] = 1'b1;
        end else begin
          y_d[i] = y_q[i] - vel_w;
        end
        if (bounce_x[i] || bounce_y[i]) begin
          dig_d[i] = (dig_q[i] == 4'd9) ? 4'd0 : dig_q[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    snd_valid_d = 1'b1;
    code_d      = code_q;
    if (stop)           code_d = SndStop;
    else if (go)        code_d = SndGo;
    else if (|bounce_y) code_d = SndPong;
    else if (|bounce_x) code_d = SndPing;
    else                snd_valid_d = 1'b0;
  end

  // Lowest-index channel with a lit segment under the pixel owns the colour.
  always_comb begin
    logic [10:0] px, py, u, v;
    logic [6:0]  segs;
    logic        hit, left, right, upper, lower, lit;
    px      = {1'b0, bus.x_px};
    py      = {1'b0, bus.y_px};
    color_d = 3'd0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < N_NUM; i++) begin
      u     = px - x_q[i];
      v     = py - y_q[i];
      segs  = seg_pattern(dig_q[i]);
      left  = (u < SegT);
      right = (u >= DigW - SegT);
      upper = (v < SegM + SegT);
      lower = (v >= SegM);
      lit   = (segs[6] & (v < SegT)) |
              (segs[5] & right & upper) |
              (segs[4] & right & lower) |
              (segs[3] & (v >= DigH - SegT)) |
              (segs[2] & left & lower) |
              (segs[1] & left & upper) |
              (segs[0] & (v >= SegM) & (v < SegM + SegT));
      if (!hit && lit && px >= x_q[i] && px < x_q[i] + DigW &&
          py >= y_q[i] && py < y_q[i] + DigH) begin
        color_d = 3'(i + 1);
        hit     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned i = 0; i < N_NUM; i++) begin
        x_q[i]   <= 11'(32 + 64 * i);
        y_q[i]   <= 11'(32 + 48 * i);
        dx_q[i]  <= 1'b1;
        dy_q[i]  <= ((i % 2) == 0);
        dig_q[i] <= 4'(i % 10);
      end
      vel_q       <= VelRst;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      snd_valid_q <= 1'b0;
      code_q      <= SndPing;
      mute_q      <= (VelRst == 3'd0);
      color_q     <= 3'd0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      dig_q       <= dig_d;
      vel_q       <= vel_d;
      inc_q       <= bus.inc_vel;
      dec_q       <= bus.dec_vel;
      snd_valid_q <= snd_valid_d;
      code_q      <= code_d;
      mute_q      <= (vel_d == 3'd0);
      color_q     <= color_d;
    end
  end

  assign bus.color_px   = color_q;
  assign bus.snd_valid  = snd_valid_q;
  assign bus.code_sound = code_q;
  assign bus.mute       = mute_q;

endmodule

// File: tb/tb_numbers_multi.sv
// Directed bench for numbers_multi: expected sounds and pixel colours are queued at
// stimulus time and popped by a monitor when the block presents them.
module tb_numbers_multi;
  localparam int NN = 2;
  localparam int XL = 624;
  localparam int YL = 452;
  localparam int W  = 16;
  localparam int H  = 28;
  localparam int T  = 4;
  localparam int M  = 12;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic probe_req = 1'b0;
  logic probe_d = 1'b0;

  numbers_multi_if bus ();

  numbers_multi #(
    .N_NUM(2), .SCR_W(640), .SCR_H(480), .DIG_W(16), .DIG_H(28),
    .SEG_T(4), .VEL_MAX(7), .VEL_RST(1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) probe_d <= probe_req;

  typedef struct { int x; int y; int exp; } probe_t;
  probe_t     pix_q[$];
  logic [1:0] snd_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the bouncing digits.
  int mx[NN], my[NN], mdx[NN], mdy[NN], mdig[NN], mvel;
  bit corner0;
  string seg_pat[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event, expected one", nm);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NN; i++) begin
      mx[i] = 32 + 64 * i;
      my[i] = 32 + 48 * i;
      mdx[i] = 1;
      mdy[i] = (i % 2 == 0) ? 1 : -1;
      mdig[i] = i % 10;
    end
    mvel = 1;
  endtask

  task automatic step_axis(input int p, input int d, input int v, input int lim,
                           output int np, output int nd, output bit b);
    np = p; nd = d; b = 0;
    if (v == 0) return;
    if (d > 0) begin
      if (p + v >= lim) begin np = lim; nd = -1; b = 1; end
      else np = p + v;
    end else begin
      if (p <= v) begin np = 0; nd = 1; b = 1; end
      else np = p - v;
    end
  endtask

  task automatic model_issue(input bit fr, input bit inc, input bit dec, output int code);
    bit bxa, bya, bxi, byi;
    int np, nd;
    bxa = 0; bya = 0; corner0 = 0; code = -1;
    if (fr) begin
      for (int i = 0; i < NN; i++) begin
        step_axis(mx[i], mdx[i], mvel, XL, np, nd, bxi);
        mx[i] = np; mdx[i] = nd;
        step_axis(my[i], mdy[i], mvel, YL, np, nd, byi);
        my[i] = np; mdy[i] = nd;
        if (bxi || byi) mdig[i] = (mdig[i] + 1) % 10;
        if (i == 0) corner0 = bxi && byi;
        bxa |= bxi;
        bya |= byi;
      end
    end
    if (inc && !dec && mvel < 7) begin
      if (mvel == 0) code = 2;
      mvel++;
    end else if (dec && !inc && mvel > 0) begin
      if (mvel == 1) code = 3;
      mvel--;
    end
    if (code < 0) code = bya ? 1 : (bxa ? 0 : -1);
  endtask

  function automatic bit bounce_next();
    bit b = 0;
    if (mvel == 0) return 0;
    for (int i = 0; i < NN; i++) begin
      if (mdx[i] > 0 ? (mx[i] + mvel >= XL) : (mx[i] <= mvel)) b = 1;
      if (mdy[i] > 0 ? (my[i] + mvel >= YL) : (my[i] <= mvel)) b = 1;
    end
    return b;
  endfunction

  function automatic bit seg_hit(input byte c, input int u, input int v);
    if (c == "a") return v < T;
    if (c == "g") return v >= M && v < M + T;
    if (c == "d") return v >= H - T;
    if (c == "f") return u < T && v < M + T;
    if (c == "b") return u >= W - T && v < M + T;
    if (c == "e") return u < T && v >= M;
    if (c == "c") return u >= W - T && v >= M;
    return 0;
  endfunction

  function automatic int model_color(input int px, input int py);
    for (int i = 0; i < NN; i++) begin
      int u = px - mx[i];
      int v = py - my[i];
      if (u >= 0 && u < W && v >= 0 && v < H) begin
        string s = seg_pat[mdig[i]];
        for (int k = 0; k < s.len(); k++)
          if (seg_hit(s[k], u, v)) return i + 1;
      end
    end
    return 0;
  endfunction

  // One cycle of strobes followed by one quiet cycle so the next level rise is an edge.
  task automatic issue(input bit fr, input bit inc, input bit dec);
    int code;
    model_issue(fr, inc, dec, code);
    if (code >= 0) snd_q.push_back(2'(code));
    bus.frame = fr; bus.inc_vel = inc; bus.dec_vel = dec;
    @(posedge clk); #1;
    bus.frame = 0; bus.inc_vel = 0; bus.dec_vel = 0;
    @(posedge clk); #1;
    if (snd_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL snd_missing: got no snd_valid, expected code %b", snd_q[0]);
      snd_q.delete();
    end
  endtask

  task automatic probe(input int px, input int py, input int exp);
    probe_t p;
    p.x = px; p.y = py; p.exp = exp;
    pix_q.push_back(p);
    bus.x_px = 10'(px); bus.y_px = 10'(py);
    probe_req = 1'b1;
    @(posedge clk); #1;
    probe_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic probe_m(input int px, input int py);
    probe(px, py, model_color(px, py));
  endtask

  task automatic probe_boxes();
    for (int i = 0; i < NN; i++) begin
      probe_m(mx[i], my[i]);
      probe_m(mx[i] + W - 1, my[i] + H - 1);
      probe_m(mx[i] + 1, my[i] + M + 1);
      probe_m(mx[i] + W - 2, my[i] + 2);
      probe_m(mx[i] + W, my[i] + H);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.frame = 0; bus.inc_vel = 0; bus.dec_vel = 0; bus.x_px = 0; bus.y_px = 0;
    fork
      forever begin
        @(negedge clk);
        if (bus.snd_valid === 1'b1) begin
          n_checks++;
          if (snd_q.size() == 0) begin
            n_fail++;
            $display("FAIL snd_unexpected: got code %b, expected no event", bus.code_sound);
          end else begin
            logic [1:0] e;
            e = snd_q.pop_front();
            if (bus.code_sound !== e) begin
              n_fail++;
              $display("FAIL snd_code: got %b, expected %b", bus.code_sound, e);
            end
          end
        end
        if (probe_d) begin
          n_checks++;
          if (pix_q.size() == 0) begin
            n_fail++;
            $display("FAIL pix_unexpected: got color %0d, expected no probe", bus.color_px);
          end else begin
            probe_t p;
            p = pix_q.pop_front();
            if (bus.color_px !== 3'(p.exp)) begin
              n_fail++;
              $display("FAIL pix(%0d,%0d): got color %0d, expected %0d",
                       p.x, p.y, bus.color_px, p.exp);
            end
          end
        end
      end
    join_none

    #3 clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_color", int'(bus.color_px), 0);
    check("rst_snd_valid", int'(bus.snd_valid), 0);
    check("rst_mute", int'(bus.mute), 0);
    check("rst_code", int'(bus.code_sound), 0);
    clr = 1'b1;
    @(posedge clk); #1;

    // Reset layout: digit 0 at (32,32), digit 1 at (96,80).
    probe(32, 32, 1);
    probe(38, 44, 0);
    probe(38, 38, 0);
    probe(47, 32, 1);
    probe(48, 32, 0);
    probe(32, 59, 1);
    probe(32, 60, 0);
    probe(108, 80, 2);
    probe(96, 80, 0);

    issue(0, 0, 1);
    check("mute_after_stop", int'(bus.mute), 1);
    issue(1, 0, 0);
    probe(32, 32, 1);
    probe(108, 80, 2);
    issue(0, 1, 0);
    check("mute_after_go", int'(bus.mute), 0);
    repeat (6) issue(0, 1, 0);
    issue(0, 1, 0);
    issue(0, 1, 1);

    // At vel 7, 84 frames bring x0 to 620 heading right; y0 bounced once (digit 1).
    repeat (84) issue(1, 0, 0);
    probe(632, 284, 1);
    probe(619, 284, 0);
    issue(1, 0, 0);
    probe(624, 277, 1);
    probe(623, 277, 0);
    probe(639, 304, 1);
    probe(624, 289, 1);
    probe_boxes();

    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      issue(1, 0, 0);
      found = corner0;
    end
    if (!found) bound_fail("corner_wait");
    // Corner at (624,0): single advance lands digit 0 back on 0, so segment a is lit.
    probe(624, 0, 1);
    probe(639, 27, 1);
    probe(640, 0, 0);
    probe_boxes();

    issue(0, 0, 1);
    issue(1, 1, 0);
    probe(618, 6, 1);
    probe_boxes();

    repeat (6) issue(0, 0, 1);
    found = bounce_next();
    for (int k = 0; k < 1000 && !found; k++) begin
      issue(1, 0, 0);
      found = bounce_next();
    end
    if (!found) bound_fail("bounce_wait");
    issue(1, 0, 1);
    check("mute_stop_with_bounce", int'(bus.mute), 1);
    probe_boxes();
    issue(1, 1, 0);
    check("mute_go_with_frame", int'(bus.mute), 0);
    probe_boxes();

    // Reset while a stop event is on the outputs.
    bus.dec_vel = 1;
    @(posedge clk); #2;
    clr = 1'b0;
    #1;
    check("midpulse_snd_valid", int'(bus.snd_valid), 0);
    check("midpulse_mute", int'(bus.mute), 0);
    check("midpulse_color", int'(bus.color_px), 0);
    check("midpulse_code", int'(bus.code_sound), 0);
    bus.dec_vel = 0;
    model_reset();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    probe(32, 32, 1);
    probe(108, 80, 2);
    issue(0, 0, 1);
    check("mute_after_reset_stop", int'(bus.mute), 1);

    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", snd_q.size() + pix_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
